// File: rtl/pc_branch_unit_pkg.sv
// rtl/pc_branch_unit_pkg.sv - shared encodings for the pc/branch unit
//
// Purpose: state encodings, flag bit indices, flag reset value and the
// helper that forces the constant flag bits (bit6=1, bit7=0).
package pc_branch_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam int FLG_CY   = 0;
  localparam int FLG_OV   = 1;
  localparam int FLG_SGN  = 2;
  localparam int FLG_ZRO  = 3;
  localparam int FLG_A    = 4;
  localparam int FLG_LE   = 5;
  localparam int FLG_ONE  = 6;
  localparam int FLG_ZERO = 7;

  localparam logic [7:0] FLAG_RST = 8'h40;

  // Bits 6 and 7 are constants so that br_cond=6 is JMP and br_cond=7 is CONT.
  function automatic logic [7:0] fix_flags(input logic [7:0] f);
    logic [7:0] r;
    r           = f;
    r[FLG_ONE]  = 1'b1;
    r[FLG_ZERO] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/pc_branch_unit_branch_cond_sel.sv
// rtl/pc_branch_unit_branch_cond_sel.sv - flag bit select with optional invert
//
// Purpose: combinational 8:1 flag mux followed by an XOR invert.
// Ports:
//   flg  - flag vector to test
//   sel  - index of the flag bit
//   inv  - invert the selected bit
//   cond - resulting branch condition
module branch_cond_sel (
  input  logic [7:0] flg,
  input  logic [2:0] sel,
  input  logic       inv,
  output logic       cond
);

  assign cond = flg[sel] ^ inv;

endmodule

// File: rtl/pc_branch_unit.sv
// rtl/pc_branch_unit.sv - program counter, flag register and conditional branch unit
//
// Purpose: owns the fetch pc, latches ALU flags and resolves branch requests.
// Optional macro FLAG_BYPASS_EN: a branch accepted on the same edge as a flag
// write tests the incoming flags instead of the registered ones.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   flg_in, flg_we        - ALU flag vector and its capture strobe
//   br_valid, br_cond,
//   br_inv, br_target     - branch request (held until br_ack)
//   stall                 - fetch back-pressure, holds pc
//   halt_req, resume      - enter / leave HALT
//   pc, flags             - fetch address, registered flag vector
//   br_ack, taken         - one-cycle branch outcome pulses
//   flush                 - bubble cycle after a taken branch
//   halted                - high while in HALT
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      flg_in,
  input  logic            flg_we,
  input  logic            br_valid,
  input  logic [2:0]      br_cond,
  input  logic            br_inv,
  input  logic [PC_W-1:0] br_target,
  input  logic            stall,
  input  logic            halt_req,
  input  logic            resume,
  output logic [PC_W-1:0] pc,
  output logic [7:0]      flags,
  output logic            br_ack,
  output logic            taken,
  output logic            flush,
  output logic            halted
);

  state_e          state_q,  state_d;
  logic [PC_W-1:0] pc_q,     pc_d;
  logic [7:0]      flags_q,  flags_d;
  logic            br_ack_q, br_ack_d;
  logic            taken_q,  taken_d;
  logic            flush_q,  flush_d;
  logic            halted_q, halted_d;

  logic [7:0]      flg_fixed;
  logic [7:0]      cond_flags;
  logic            cond;
  logic [PC_W-1:0] pc_inc;

  assign flg_fixed = fix_flags(flg_in);
  assign pc_inc    = pc_q + PC_W'(1);

`ifdef FLAG_BYPASS_EN
  // Lets a compare and its dependent jump issue on consecutive cycles.
  assign cond_flags = flg_we ? flg_fixed : flags_q;
`else
  assign cond_flags = flags_q;
`endif

  branch_cond_sel u_cond_sel (
    .flg  (cond_flags),
    .sel  (br_cond),
    .inv  (br_inv),
    .cond (cond)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    flags_d  = flg_we ? flg_fixed : flags_q;
    br_ack_d = 1'b0;
    taken_d  = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (!stall) begin
          if (br_valid) begin
            br_ack_d = 1'b1;
            taken_d  = cond;
            if (cond) begin
              pc_d    = br_target;
              state_d = ST_FLUSH;
            end else begin
              pc_d = pc_inc;
            end
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      ST_FLUSH: begin
        // The bubble lasts one cycle; a stall here only keeps pc on the target.
        if (halt_req) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_RUN;
          if (!stall) pc_d = pc_inc;
        end
      end
      ST_HALT: begin
        if (resume && !halt_req) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    flush_d  = (state_d == ST_FLUSH);
    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      flags_q  <= FLAG_RST;
      br_ack_q <= 1'b0;
      taken_q  <= 1'b0;
      flush_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      flags_q  <= flags_d;
      br_ack_q <= br_ack_d;
      taken_q  <= taken_d;
      flush_q  <= flush_d;
      halted_q <= halted_d;
    end
  end

  assign pc     = pc_q;
  assign flags  = flags_q;
  assign br_ack = br_ack_q;
  assign taken  = taken_q;
  assign flush  = flush_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// tb/tb_pc_branch_unit.sv - self-checking bench for pc_branch_unit
module tb_pc_branch_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] flg_in = '0;
  logic       flg_we = 1'b0;
  logic       br_valid = 1'b0;
  logic [2:0] br_cond = '0;
  logic       br_inv = 1'b0;
  logic [7:0] br_target = '0;
  logic       stall = 1'b0;
  logic       halt_req = 1'b0;
  logic       resume = 1'b0;
  logic [7:0] pc;
  logic [7:0] flags;
  logic       br_ack, taken, flush, halted;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  pc_branch_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .flg_in(flg_in), .flg_we(flg_we),
    .br_valid(br_valid), .br_cond(br_cond), .br_inv(br_inv),
    .br_target(br_target), .stall(stall), .halt_req(halt_req),
    .resume(resume), .pc(pc), .flags(flags), .br_ack(br_ack),
    .taken(taken), .flush(flush), .halted(halted)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 = running, 1 = bubble after taken jump, 2 = halted.
  int       m_pc = 0;
  int       m_mode = 0;
  bit [7:0] m_flags = 8'h40;
  bit       m_ack = 0;
  bit       m_taken = 0;

  always @(posedge clk) begin
    bit [7:0] src;
    bit       c;
    m_ack   = 0;
    m_taken = 0;
    if (rst) begin
      m_pc = 0; m_mode = 0; m_flags = 8'h40;
    end else begin
      src = m_flags;
`ifdef FLAG_BYPASS_EN
      if (flg_we) src = {2'b01, flg_in[5:0]};
`endif
      c = src[br_cond] ^ br_inv;
      if (m_mode == 0) begin
        if (halt_req) m_mode = 2;
        else if (!stall) begin
          if (br_valid) begin
            m_ack = 1; m_taken = c;
            if (c) begin m_pc = br_target; m_mode = 1; end
            else m_pc = (m_pc + 1) % 256;
          end else m_pc = (m_pc + 1) % 256;
        end
      end else if (m_mode == 1) begin
        if (halt_req) m_mode = 2;
        else begin
          m_mode = 0;
          if (!stall) m_pc = (m_pc + 1) % 256;
        end
      end else begin
        if (resume && !halt_req) m_mode = 0;
      end
      if (flg_we) m_flags = {2'b01, flg_in[5:0]};
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("m_pc",     pc,     m_pc);
      chk("m_flags",  flags,  m_flags);
      chk("m_br_ack", br_ack, m_ack);
      chk("m_taken",  taken,  m_taken);
      chk("m_flush",  flush,  m_mode == 1);
      chk("m_halted", halted, m_mode == 2);
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    flg_we = 0; br_valid = 0; stall = 0; halt_req = 0; resume = 0;
  endtask

  task automatic jmp_to(input logic [7:0] t);
    br_valid = 1; br_cond = 3'd6; br_inv = 0; br_target = t;
    cyc();
    br_valid = 0;
    cyc();
  endtask

  initial begin
    logic [7:0] hold_pc;
    rst = 1;
    cyc();
    check_en = 1;
    chk("rst_pc", pc, 8'h00);
    chk("rst_flags", flags, 8'h40);
    chk("rst_pulses", {br_ack, taken, flush, halted}, 4'b0000);
    rst = 0;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk("free_pc", pc, i);
    end

    // JZ taken: flags capture then jump to 0x40
    flg_in = 8'h08; flg_we = 1;
    cyc();
    chk("cap_flags", flags, 8'h48);
    flg_we = 0;
    br_valid = 1; br_cond = 3'd3; br_inv = 0; br_target = 8'h40;
    cyc();
    chk("jz_ack", br_ack, 1);
    chk("jz_taken", taken, 1);
    chk("jz_pc", pc, 8'h40);
    chk("jz_flush", flush, 1);
    br_valid = 0;
    cyc();
    chk("jz_flush_off", flush, 0);
    chk("jz_pc_next", pc, 8'h41);

    // JNZ not taken at 0x10
    jmp_to(8'h0F);
    chk("pc_at_10", pc, 8'h10);
    br_valid = 1; br_cond = 3'd3; br_inv = 1; br_target = 8'h80;
    cyc();
    chk("jnz_ack", br_ack, 1);
    chk("jnz_taken", taken, 0);
    chk("jnz_pc", pc, 8'h11);
    chk("jnz_flush", flush, 0);
    br_valid = 0;

    // Wrap
    jmp_to(8'hFD);
    chk("pc_at_fe", pc, 8'hFE);
    cyc();
    chk("wrap_ff", pc, 8'hFF);
    cyc();
    chk("wrap_00", pc, 8'h00);

    // Stall with branch held
    hold_pc = pc;
    stall = 1; br_valid = 1; br_cond = 3'd6; br_inv = 0; br_target = 8'h33;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_pc", pc, hold_pc);
      chk("stall_ack", br_ack, 0);
    end
    stall = 0;
    cyc();
    chk("stall_rel_taken", taken, 1);
    chk("stall_rel_pc", pc, 8'h33);
    br_valid = 0;
    cyc();

    // Halt at 0x20
    jmp_to(8'h1F);
    chk("pc_at_20", pc, 8'h20);
    halt_req = 1;
    cyc();
    halt_req = 0;
    br_valid = 1; br_cond = 3'd6; br_target = 8'h55;
    chk("halt_on", halted, 1);
    chk("halt_pc", pc, 8'h20);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("halt_hold_pc", pc, 8'h20);
      chk("halt_no_ack", br_ack, 0);
    end
    br_valid = 0;
    halt_req = 1; resume = 1;
    cyc();
    chk("halt_and_resume", halted, 1);
    halt_req = 0;
    cyc();
    chk("resume_halted", halted, 0);
    chk("resume_pc", pc, 8'h20);
    resume = 0;
    cyc();
    chk("resume_inc", pc, 8'h21);
    halt_req = 1;
    cyc();
    halt_req = 0;
    chk("halt2_on", halted, 1);
    rst = 1;
    cyc();
    rst = 0;
    chk("halt_rst_pc", pc, 8'h00);
    chk("halt_rst_halted", halted, 0);

    // CONT never taken
    br_valid = 1; br_cond = 3'd7; br_inv = 0; br_target = 8'h99;
    cyc();
    chk("cont_taken", taken, 0);
    chk("cont_pc", pc, 8'h01);
    idle();

    // Random phase, model-checked every cycle
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      flg_in    = 8'($urandom);
      flg_we    = ($urandom_range(0, 2) == 0);
      br_valid  = $urandom_range(0, 1) == 1;
      br_cond   = 3'($urandom);
      br_inv    = $urandom_range(0, 1) == 1;
      br_target = 8'($urandom);
      stall     = ($urandom_range(0, 3) == 0);
      halt_req  = ($urandom_range(0, 19) == 0);
      resume    = ($urandom_range(0, 3) == 0);
      cyc();
    end
    rst = 0;
    idle();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
Downstream neighbour of the 8-bit ALU. It latches the ALU's 8-bit flag vector into a flag register and evaluates conditional jumps against that register. It also owns the program counter. Instruction fetch consumes pc, and the decode/issue logic drives branch requests and stalls.

Parameters:
PC_W, 8, program counter width in bits
RESET_PC, 0, pc value loaded on reset

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
flg_in  input  8  flag vector from ALU (bit0 CY, bit1 OV, bit2 SGN, bit3 ZRO, bit4 CY.~ZRO, bit5 SGN+ZRO, bit6 1, bit7 0)
flg_we  input  1  capture flg_in into the flag register this cycle
br_valid  input  1  branch request present; held until br_ack
br_cond  input  3  index of the flag bit to test
br_inv  input  1  invert the tested bit (JNZ, JNC, ...)
br_target  input  PC_W  jump destination
stall  input  1  hold pc (fetch back-pressure)
halt_req  input  1  enter HALT
resume  input  1  leave HALT
pc  output  PC_W  current fetch address
flags  output  8  registered flag vector
br_ack  output  1  1-cycle pulse: branch request consumed (taken or not)
taken  output  1  1-cycle pulse, coincident with br_ack, when the condition was true
flush  output  1  high for the bubble cycle after a taken branch
halted  output  1  high while in HALT

Behaviour:
- Reset (rst=1 at an edge), with priority over everything:
  - pc=RESET_PC, flags=8'h40, br_ack=0, taken=0, flush=0, halted=0, state=RUN.
  - Mid-operation reset discards any pending branch or halt.
- Flag register:
  - On flg_we, flags[5:0] ← flg_in[5:0]. flags[6] is forced to 1 and flags[7] to 0 regardless of flg_in.
  - Flags update in every state, including HALT and FLUSH.
  - flags is visible the cycle after the capture edge.
- Condition: cond = flags[br_cond] XOR br_inv.
  - br_cond=6 with inv=0 gives unconditional JMP.
  - br_cond=7 with inv=0 gives CONT (never taken).
- FSM states: RUN, FLUSH, HALT. Per-edge priority is rst > halt_req > stall > branch > increment.
- RUN:
  - halt_req → HALT, pc held.
  - Otherwise stall → pc held, no br_ack; br_valid must stay asserted.
  - Otherwise br_valid → br_ack=1 next cycle.
    - If cond: pc ← br_target, taken=1, state → FLUSH.
    - If not cond: pc ← pc+1, taken=0, stay in RUN.
  - Otherwise pc ← pc+1.
- FLUSH:
  - flush=1 and pc holds br_target for exactly one cycle; br_valid is ignored (no ack).
  - Next state is RUN, or HALT if halt_req. stall in FLUSH extends the hold, but flush deasserts after one cycle.
- HALT:
  - halted=1, pc frozen, br_valid ignored.
  - resume → RUN next edge; pc then increments on the following RUN edges.
  - halt_req and resume together keep the block in HALT.
- Arithmetic: pc+1 is modulo 2^PC_W, so 8'hFF wraps to 8'h00 with no flag or side effect.
- Latency: branch decision is 1 cycle from a br_valid edge in RUN with no stall; target is fetched on the following cycle.
- Back-to-back branches: a second br_valid is accepted only in RUN, i.e. no earlier than 2 cycles after a taken branch and 1 cycle after a not-taken branch.

Optional Feature:
FLAG_BYPASS_EN
- Defined: when flg_we and br_valid are accepted on the same edge, the condition uses flg_in (with bit6=1, bit7=0 forced) instead of flags. This lets a compare-and-jump pair issue in consecutive cycles.
- Undefined: the condition always uses the registered flags, i.e. the pre-update value. Issue logic must insert one cycle between a flag-setting op and a dependent branch.

Decomposition:
- Shared package holds:
  - state encodings ST_RUN=2'd0, ST_FLUSH=2'd1, ST_HALT=2'd2
  - flag bit indices FLG_CY=0, FLG_OV=1, FLG_SGN=2, FLG_ZRO=3, FLG_A=4, FLG_LE=5, FLG_ONE=6, FLG_ZERO=7
  - FLAG_RST=8'h40
- One natural sub-module, branch_cond_sel: an 8:1 bit mux plus XOR invert taking (flag vector, br_cond, br_inv) and producing cond. It is combinational and reused by the bypass path.

Test Plan:
- Reset then 5 free-run cycles → pc 0,1,2,3,4,5; flags=8'h40; all pulses 0.
- Capture flg_in=8'h08 (ZRO) with flg_we; next cycle br_valid, cond=3, inv=0, target=8'h40 → br_ack=taken=1; pc=8'h40; flush=1 for 1 cycle; pc=8'h41 after.
- Same flags, br_cond=3, inv=1 (JNZ) at pc=8'h10 → br_ack=1, taken=0, pc=8'h11, no flush.
- pc=8'hFE, 2 free cycles → 8'hFF then 8'h00.
- stall=1 for 3 cycles with br_valid held (cond=6) → pc frozen, no br_ack; on stall release, taken=1 and pc=target.
- halt_req at pc=8'h20 → halted=1, pc stays 8'h20 for 4 cycles ignoring br_valid; resume → halted=0, pc=8'h21 next edge. Repeat with rst asserted in HALT → pc=RESET_PC, halted=0.
